median_line_loader: RTL and testbench

//  Writer side of the median filter's three-bank line memory. Takes a raster pixel stream,

---
 rtl/median_line_loader_pkg.sv | 45 ++++
 rtl/median_line_loader_if.sv | 23 ++
 rtl/median_line_loader_pixel_packer.sv | 63 ++++++
 rtl/median_line_loader.sv | 157 +++++++++++++++
 tb/tb_median_line_loader.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/median_line_loader_pkg.sv
// -----------------------------------------------------------------------------
// median_line_loader_pkg
//   Shared types and helpers for the median filter line loader.
//   - bank_t      : which of the three line-memory banks a row lands in
//   - ldr_state_t : loader FSM states (also exported on the debug port)
//   - next_bank() : A -> B -> C -> A row rotation
//   - bits_for()  : counter width for a 0..n-1 range, never narrower than 1
// -----------------------------------------------------------------------------
package median_line_loader_pkg;

   // Default geometry: 320-pixel rows packed four pixels per word.
   localparam int DEFAULT_IMG_WIDTH = 320;
   localparam int WORDS_PER_LINE    = DEFAULT_IMG_WIDTH / 4;

   typedef enum logic [1:0] {
      BANK_A = 2'd0,
      BANK_B = 2'd1,
      BANK_C = 2'd2
   } bank_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } ldr_state_t;

   function automatic int words_per_line(input int img_width);
      return img_width / 4;
   endfunction

   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bank_t next_bank(input bank_t b);
      bank_t nb;
      case (b)
         BANK_A:  nb = BANK_B;
         BANK_B:  nb = BANK_C;
         default: nb = BANK_A;
      endcase
      return nb;
   endfunction

endpackage

// File: rtl/median_line_loader_if.sv
// -----------------------------------------------------------------------------
// median_line_loader_if
//   Raster pixel stream into the line loader.
//   Handshake: a pixel moves on every rising clock edge where pix_valid and
//   pix_ready are both high; the source holds pix_data stable while pix_valid
//   is high and not yet accepted, and pix_ready may be low for any number of
//   cycles.
//   Signals:
//     pix_valid  source -> loader   pix_data is meaningful
//     pix_data   source -> loader   raster-order pixel
//     pix_ready  loader -> source   loader takes a pixel this cycle
//   Modports: master = pixel source, slave = loader.
// -----------------------------------------------------------------------------
interface median_line_loader_if #(
   parameter int PIXEL_DATA_WIDTH = 8
);
   logic                        pix_valid;
   logic [PIXEL_DATA_WIDTH-1:0] pix_data;
   logic                        pix_ready;

   modport master (output pix_valid, output pix_data, input pix_ready);
   modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/median_line_loader_pixel_packer.sv
// -----------------------------------------------------------------------------
// median_line_loader_pixel_packer
//   4:1 shift packer. The first pixel of a group ends up in the most
//   significant byte lane, the fourth in the least significant one.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     i_clear        discard any partial group (frame start)
//     i_xfer         a pixel is transferred this cycle
//     i_pix          the pixel being transferred
//     o_group_end    this transfer completes a word (combinational)
//     o_word         last completed word (registered)
//     o_word_valid   one-cycle strobe in the cycle after o_group_end
// -----------------------------------------------------------------------------
module median_line_loader_pixel_packer #(
   parameter int PIX_W  = 8,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_xfer,
   input  logic [PIX_W-1:0]  i_pix,
   output logic              o_group_end,
   output logic [WORD_W-1:0] o_word,
   output logic              o_word_valid
);

   // The first three pixels of a group wait here until the fourth arrives.
   localparam int HOLD_W = WORD_W - PIX_W;

   logic [1:0]        r_lane;
   logic [HOLD_W-1:0] r_hold;
   logic [WORD_W-1:0] r_word;
   logic              r_word_valid;

   assign o_group_end  = i_xfer && (r_lane == 2'd3);
   assign o_word       = r_word;
   assign o_word_valid = r_word_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lane       <= 2'd0;
         r_hold       <= '0;
         r_word       <= '0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_clear) begin
            r_lane <= 2'd0;
            r_hold <= '0;
         end else if (i_xfer) begin
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
               r_word       <= {r_hold, i_pix};
               r_word_valid <= 1'b1;
            end else begin
               r_hold <= {r_hold[HOLD_W-PIX_W-1:0], i_pix};
            end
         end
      end
   end

endmodule

// File: rtl/median_line_loader.sv
// -----------------------------------------------------------------------------
// median_line_loader
//   Writer side of the median filter's three-bank line memory. Packs a raster
//   pixel stream four pixels per word and writes row r into bank r mod 3, at
//   address (r / 3) * IMG_WIDTH/4 + column word.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     start                 one-cycle pulse, arms a frame load (IDLE only)
//     pix (slave)           pixel stream: pix_valid, pix_data, pix_ready
//     w_ena_a/b/c           bank write enables, at most one high
//     w_addr, w_data        shared write address and packed word
//     rows_loaded           complete rows written this frame
//     busy                  high in LOAD and DONE
//     frame_done            pulse together with the frame's last write
//     dbg_state             current FSM state
// -----------------------------------------------------------------------------
module median_line_loader
   import median_line_loader_pkg::*;
#(
   parameter int PIXEL_DATA_WIDTH = 8,
   parameter int MEM_DATA_WIDTH   = 32,
   parameter int MEM_ADDR_WIDTH   = 14,
   parameter int IMG_WIDTH        = 320,
   parameter int IMG_HEIGHT       = 320
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   median_line_loader_if.slave               pix,
   output logic                              w_ena_a,
   output logic                              w_ena_b,
   output logic                              w_ena_c,
   output logic [MEM_ADDR_WIDTH-1:0]         w_addr,
   output logic [MEM_DATA_WIDTH-1:0]         w_data,
   output logic [$clog2(IMG_HEIGHT+1)-1:0]   rows_loaded,
   output logic                              busy,
   output logic                              frame_done,
   output ldr_state_t                        dbg_state
);

   localparam int WPL    = words_per_line(IMG_WIDTH);
   localparam int COL_W  = bits_for(WPL);
   localparam int ROWS_W = $clog2(IMG_HEIGHT + 1);

   localparam logic [COL_W-1:0]          LAST_COL  = COL_W'(WPL - 1);
   localparam logic [ROWS_W-1:0]         LAST_ROW  = ROWS_W'(IMG_HEIGHT - 1);
   localparam logic [ROWS_W-1:0]         ROWS_MAX  = ROWS_W'(IMG_HEIGHT);
   localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_STEP = MEM_ADDR_WIDTH'(WPL);

   ldr_state_t                r_state;
   ldr_state_t                w_next;
   logic [COL_W-1:0]          r_col;
   bank_t                     r_bank;
   logic [MEM_ADDR_WIDTH-1:0] r_base;
   logic [ROWS_W-1:0]         r_rows;
   logic [MEM_ADDR_WIDTH-1:0] r_wr_addr;
   bank_t                     r_wr_bank;
   logic                      r_frame_done;

   logic                      w_ready;
   logic                      w_clear;
   logic                      w_xfer;
   logic                      w_group_end;
   logic                      w_row_end;
   logic                      w_frame_end;
   logic [MEM_DATA_WIDTH-1:0] w_word;
   logic                      w_word_valid;

   assign w_ready     = (r_state == LOAD);
   assign w_clear     = (r_state == IDLE) && start;
   assign w_xfer      = pix.pix_valid && w_ready;
   assign w_row_end   = w_group_end && (r_col == LAST_COL);
   // Last pixel of the last row: its word is written while in DONE.
   assign w_frame_end = w_row_end && (r_rows == LAST_ROW);

   median_line_loader_pixel_packer #(
      .PIX_W  (PIXEL_DATA_WIDTH),
      .WORD_W (MEM_DATA_WIDTH)
   ) u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (w_clear),
      .i_xfer       (w_xfer),
      .i_pix        (pix.pix_data),
      .o_group_end  (w_group_end),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = LOAD;
         LOAD:    if (w_frame_end) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Address / row bookkeeping. The write address and bank are captured on
   // the transfer that completes a word, so they line up with the packer's
   // registered word one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col        <= '0;
         r_bank       <= BANK_A;
         r_base       <= '0;
         r_rows       <= '0;
         r_wr_addr    <= '0;
         r_wr_bank    <= BANK_A;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_clear) begin
            r_col  <= '0;
            r_bank <= BANK_A;
            r_base <= '0;
            r_rows <= '0;
         end else if (w_group_end) begin
            r_wr_addr    <= r_base + MEM_ADDR_WIDTH'(r_col);
            r_wr_bank    <= r_bank;
            r_frame_done <= w_frame_end;
            if (w_row_end) begin
               r_col  <= '0;
               r_bank <= next_bank(r_bank);
               // All three banks share one base; it steps once per A/B/C triple.
               if (r_bank == BANK_C) r_base <= r_base + ADDR_STEP;
               if (r_rows != ROWS_MAX) r_rows <= r_rows + ROWS_W'(1);
            end else begin
               r_col <= r_col + COL_W'(1);
            end
         end
      end
   end

   assign pix.pix_ready = w_ready;
   assign w_ena_a       = w_word_valid && (r_wr_bank == BANK_A);
   assign w_ena_b       = w_word_valid && (r_wr_bank == BANK_B);
   assign w_ena_c       = w_word_valid && (r_wr_bank == BANK_C);
   assign w_addr        = r_wr_addr;
   assign w_data        = w_word;
   assign rows_loaded   = r_rows;
   assign busy          = (r_state != IDLE);
   assign frame_done    = r_frame_done;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_median_line_loader.sv
module tb_median_line_loader;
   import median_line_loader_pkg::*;

   localparam int PW     = 8;
   localparam int DW     = 32;
   localparam int AW     = 14;
   localparam int IW     = 8;
   localparam int IH     = 4;
   localparam int WPL    = IW / 4;
   localparam int NPIX   = IW * IH;
   localparam int NWORDS = NPIX / 4;
   localparam int RW     = $clog2(IH + 1);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   logic start;
   always #5 clk = ~clk;

   logic          w_ena_a, w_ena_b, w_ena_c;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   logic [RW-1:0] rows_loaded;
   logic          busy, frame_done;
   ldr_state_t    dbg_state;

   median_line_loader_if #(.PIXEL_DATA_WIDTH(PW)) pix_if ();

   median_line_loader #(
      .PIXEL_DATA_WIDTH (PW),
      .MEM_DATA_WIDTH   (DW),
      .MEM_ADDR_WIDTH   (AW),
      .IMG_WIDTH        (IW),
      .IMG_HEIGHT       (IH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pix         (pix_if),
      .w_ena_a     (w_ena_a),
      .w_ena_b     (w_ena_b),
      .w_ena_c     (w_ena_c),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .rows_loaded (rows_loaded),
      .busy        (busy),
      .frame_done  (frame_done),
      .dbg_state   (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      logic [7:0]    ep;
      logic [1:0]    bank;
      logic [AW-1:0] addr;
      logic [RW-1:0] rows;
      logic          done;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_fail = 0;
   int   epoch = 0;
   int   seen_epoch = 0;
   int   xfer_cnt = 0;
   int   wr_cnt = 0;
   logic pending = 1'b0;
   logic [DW-1:0] mem_a [4];
   logic [DW-1:0] mem_b [4];
   logic [DW-1:0] mem_c [4];
   logic [PW-1:0] ramp [NPIX];
   logic [PW-1:0] alt  [NPIX];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Model: word k of a frame lives in row k/WPL, column k%WPL; that row
   // goes to bank row%3 at address (row/3)*WPL + column.
   task automatic push_frame(input logic [PW-1:0] px [NPIX]);
      epoch++;
      for (int k = 0; k < NWORDS; k++) begin
         exp_t e;
         int   row;
         int   col;
         row    = k / WPL;
         col    = k % WPL;
         e.ep   = 8'(epoch);
         e.bank = 2'(row % 3);
         e.addr = AW'((row / 3) * WPL + col);
         e.rows = RW'((col == WPL - 1) ? row + 1 : row);
         e.done = (k == NWORDS - 1);
         e.data = {px[4*k], px[4*k+1], px[4*k+2], px[4*k+3]};
         exp_q.push_back(e);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      int   n_en;
      int   bank;
      exp_t e;
      if (epoch != seen_epoch) begin
         seen_epoch = epoch;
         xfer_cnt   = 0;
         pending    = 1'b0;
         wr_cnt     = 0;
         for (int i = 0; i < 4; i++) begin
            mem_a[i] = 32'hDEADBEEF;
            mem_b[i] = 32'hDEADBEEF;
            mem_c[i] = 32'hDEADBEEF;
         end
      end
      n_en = int'(w_ena_a) + int'(w_ena_b) + int'(w_ena_c);
      chk("write_strobe", n_en, pending ? 1 : 0);
      if (n_en == 1) begin
         wr_cnt++;
         bank = w_ena_a ? 0 : (w_ena_b ? 1 : 2);
         while (exp_q.size() > 0 && exp_q[0].ep != 8'(seen_epoch)) void'(exp_q.pop_front());
         if (exp_q.size() == 0) begin
            chk("exp_available", 0, 1);
         end else begin
            e = exp_q.pop_front();
            chk("w_bank", bank, 32'(e.bank));
            chk("w_addr", 32'(w_addr), 32'(e.addr));
            chk("w_data", w_data, e.data);
            chk("rows_loaded", 32'(rows_loaded), 32'(e.rows));
            chk("frame_done", 32'(frame_done), 32'(e.done));
         end
         if (w_addr < 4) begin
            case (bank)
               0:       mem_a[w_addr[1:0]] = w_data;
               1:       mem_b[w_addr[1:0]] = w_data;
               default: mem_c[w_addr[1:0]] = w_data;
            endcase
         end
      end else begin
         chk("frame_done_idle", 32'(frame_done), 0);
      end
      pending = pix_if.pix_valid && pix_if.pix_ready && (xfer_cnt % 4 == 3);
      if (pix_if.pix_valid && pix_if.pix_ready) xfer_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pix(input logic [PW-1:0] v);
      int   t;
      logic got;
      t   = 0;
      got = 1'b0;
      pix_if.pix_valid = 1'b1;
      pix_if.pix_data  = v;
      while (!got && t < 20) begin
         @(negedge clk);
         if (pix_if.pix_ready) got = 1'b1;
         tick();
         t++;
      end
      if (!got) chk("pix_accept_timeout", 0, 1);
      pix_if.pix_valid = 1'b0;
   endtask

   task automatic send_range(input logic [PW-1:0] px [NPIX], input int lo, input int hi, input bit gap);
      for (int i = lo; i < hi; i++) begin
         send_pix(px[i]);
         if (gap) tick();
      end
   endtask

   task automatic start_frame(input logic [PW-1:0] px [NPIX]);
      push_frame(px);
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("load_ready", 32'(pix_if.pix_ready), 1);
      chk("load_busy", 32'(busy), 1);
      chk("load_rows_zero", 32'(rows_loaded), 0);
      chk("load_state", 32'(dbg_state), 32'(LOAD));
      tick();
   endtask

   task automatic frame_end_check();
      repeat (3) tick();
      chk("write_count", wr_cnt, NWORDS);
      chk("end_state", 32'(dbg_state), 32'(IDLE));
      chk("end_busy", 32'(busy), 0);
      chk("end_ready", 32'(pix_if.pix_ready), 0);
      chk("end_rows", 32'(rows_loaded), IH);
   endtask

   // Hand-computed bank image of a 0x00..0x1F ramp.
   task automatic literal_check();
      chk("A0", mem_a[0], 32'h00010203);
      chk("A1", mem_a[1], 32'h04050607);
      chk("B0", mem_b[0], 32'h08090A0B);
      chk("B1", mem_b[1], 32'h0C0D0E0F);
      chk("C0", mem_c[0], 32'h10111213);
      chk("C1", mem_c[1], 32'h14151617);
      chk("A2", mem_a[2], 32'h18191A1B);
      chk("A3", mem_a[3], 32'h1C1D1E1F);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ena"}, {29'd0, w_ena_a, w_ena_b, w_ena_c}, 0);
      chk({tag, "_addr"}, 32'(w_addr), 0);
      chk({tag, "_data"}, w_data, 0);
      chk({tag, "_rows"}, 32'(rows_loaded), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(frame_done), 0);
      chk({tag, "_ready"}, 32'(pix_if.pix_ready), 0);
      chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n            = 1'b0;
      start            = 1'b0;
      pix_if.pix_valid = 1'b0;
      pix_if.pix_data  = '0;
      for (int i = 0; i < NPIX; i++) begin
         ramp[i] = PW'(i);
         alt[i]  = PW'(8'hA0 ^ (i * 7));
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      tick();
      rst_n = 1'b1;

      // 1: back-to-back ramp
      start_frame(ramp);
      send_range(ramp, 0, NPIX, 1'b0);
      frame_end_check();
      literal_check();

      // 2: valid toggling 1/0
      start_frame(ramp);
      send_range(ramp, 0, NPIX, 1'b1);
      frame_end_check();
      literal_check();

      // 3: pixels offered while idle are not consumed
      pix_if.pix_valid = 1'b1;
      pix_if.pix_data  = 8'hEE;
      repeat (4) begin
         @(negedge clk);
         chk("idle_ready", 32'(pix_if.pix_ready), 0);
         tick();
      end
      pix_if.pix_valid = 1'b0;
      start_frame(ramp);
      send_range(ramp, 0, NPIX, 1'b0);
      frame_end_check();
      literal_check();

      // 4: asynchronous reset mid-frame, then a clean frame
      start_frame(ramp);
      send_range(ramp, 0, 13, 1'b0);
      rst_n = 1'b0;
      epoch++;
      #1;
      check_zero("async_reset");
      tick();
      rst_n = 1'b1;
      start_frame(ramp);
      send_range(ramp, 0, NPIX, 1'b0);
      frame_end_check();
      literal_check();

      // 5: start ignored in LOAD and DONE, reload from IDLE
      start_frame(alt);
      send_range(alt, 0, 10, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("mid_state", 32'(dbg_state), 32'(LOAD));
      chk("mid_rows", 32'(rows_loaded), 1);
      chk("mid_ready", 32'(pix_if.pix_ready), 1);
      tick();
      send_range(alt, 10, NPIX, 1'b0);
      @(negedge clk);
      chk("done_state", 32'(dbg_state), 32'(DONE));
      chk("done_ready", 32'(pix_if.pix_ready), 0);
      chk("done_busy", 32'(busy), 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("after_done_state", 32'(dbg_state), 32'(IDLE));
      chk("after_done_busy", 32'(busy), 0);
      frame_end_check();
      start_frame(ramp);
      send_range(ramp, 0, NPIX, 1'b0);
      frame_end_check();
      literal_check();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
